wts_i2s_tx: RTL and testbench



---
 rtl/wts_i2s_pkg.sv | 12 +
 rtl/wts_i2s_tx.sv | 72 +++++++
 tb/tb_wts_i2s_tx.sv | 130 +++++++++++++
 3 files changed

// File: rtl/wts_i2s_pkg.sv
// wts_i2s_pkg: shared constants and the 12-to-16 bit sample conversion for the I2S transmitter.
package wts_i2s_pkg;
    localparam int FRAME_BITS = 32;
    localparam int SLOT_BITS = 16;
    localparam int LRCLK_HIGH_FIRST = 15;
    localparam int LRCLK_HIGH_LAST = 30;

    // Left-justify into a 16-bit slot; offset-binary input gets its MSB flipped to become two's complement.
    function automatic logic [15:0] conv12to16(input logic [11:0] x, input logic signed_mode);
        return signed_mode ? {x, 4'b0000} : {~x[11], x[10:0], 4'b0000};
    endfunction
endpackage

// File: rtl/wts_i2s_tx.sv
// wts_i2s_tx: serializes the 12-bit left/right mixer outputs as a Philips I2S stream,
// with BCLK and LRCLK derived from clk by a divider.
module wts_i2s_tx
    import wts_i2s_pkg::*;
#(
    parameter int BCLK_DIV = 8,
    parameter bit INPUT_SIGNED = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [11:0] left_in,
    input  logic [11:0] right_in,
    output logic        sample_strobe,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata
);
    localparam int CNT_W = $clog2(FRAME_BITS);
    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

    logic [7:0] div_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [FRAME_BITS-1:0] shift;
    logic [SLOT_BITS-1:0] left_word, right_word;
    logic tick, fall, lr_next;
    logic [CNT_W-1:0] n;

    assign left_word = conv12to16(left_in, INPUT_SIGNED);
    assign right_word = conv12to16(right_in, INPUT_SIGNED);
    assign tick = div_cnt == DIV_LAST;
    assign fall = tick && i2s_bclk;
    assign n = bit_cnt + 1'b1;
    // LRCLK switches one bit early so it leads each word's MSB.
    assign lr_next = n >= CNT_W'(LRCLK_HIGH_FIRST) && n <= CNT_W'(LRCLK_HIGH_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            bit_cnt <= '1;
            shift <= '0;
            i2s_bclk <= 1'b0;
            i2s_lrclk <= 1'b0;
            i2s_sdata <= 1'b0;
            sample_strobe <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            bit_cnt <= '1;
            shift <= '0;
            i2s_bclk <= 1'b0;
            i2s_lrclk <= 1'b0;
            i2s_sdata <= 1'b0;
            sample_strobe <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 8'd1;
            sample_strobe <= fall && n == '0;
            if (tick)
                i2s_bclk <= ~i2s_bclk;
            if (fall) begin
                bit_cnt <= n;
                i2s_lrclk <= lr_next;
                if (n == '0) begin
                    shift <= {left_word, right_word};
                    i2s_sdata <= left_word[SLOT_BITS-1];
                end else begin
                    shift <= shift << 1;
                    i2s_sdata <= shift[FRAME_BITS-2];
                end
            end
        end
    end
endmodule

// File: tb/tb_wts_i2s_tx.sv
// tb_wts_i2s_tx: three transmitter variants checked cycle by cycle against a
// time-indexed reference model of the I2S frame.
module tb_wts_i2s_tx;
    logic clk = 0;
    logic rst, enable;
    logic [11:0] lin [3];
    logic [11:0] rin [3];
    logic [2:0] bclk, lrclk, sdata, strobe;
    logic [2:0] rnd_on;
    int n_checks = 0, n_fail = 0;
    int dv [3] = '{8, 8, 1};
    bit sg [3] = '{0, 1, 0};
    int t [3] = '{0, 0, 0};
    logic [31:0] frame [3];

    always #5 clk = ~clk;

    wts_i2s_tx #(.BCLK_DIV(8), .INPUT_SIGNED(0)) u0 (.clk(clk), .reset(rst), .enable(enable),
        .left_in(lin[0]), .right_in(rin[0]), .sample_strobe(strobe[0]), .i2s_bclk(bclk[0]),
        .i2s_lrclk(lrclk[0]), .i2s_sdata(sdata[0]));
    wts_i2s_tx #(.BCLK_DIV(8), .INPUT_SIGNED(1)) u1 (.clk(clk), .reset(rst), .enable(enable),
        .left_in(lin[1]), .right_in(rin[1]), .sample_strobe(strobe[1]), .i2s_bclk(bclk[1]),
        .i2s_lrclk(lrclk[1]), .i2s_sdata(sdata[1]));
    wts_i2s_tx #(.BCLK_DIV(1), .INPUT_SIGNED(0)) u2 (.clk(clk), .reset(rst), .enable(enable),
        .left_in(lin[2]), .right_in(rin[2]), .sample_strobe(strobe[2]), .i2s_bclk(bclk[2]),
        .i2s_lrclk(lrclk[2]), .i2s_sdata(sdata[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sample value scaled by 16 and written as a 16-bit two's complement word.
    function automatic logic [15:0] ref_word(input logic [11:0] x, input bit s);
        int v;
        v = s ? (x >= 12'h800 ? int'(x) - 4096 : int'(x)) : int'(x) - 2048;
        return 16'(v * 16);
    endfunction

    // t counts enabled clk edges since idle; everything follows from t and the divider.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            int nb;
            logic e_lr, e_sd, e_st;
            t[i] = (rst || !enable) ? 0 : t[i] + 1;
            e_st = t[i] % (64 * dv[i]) == 2 * dv[i];
            if (e_st)
                frame[i] = {ref_word(lin[i], sg[i]), ref_word(rin[i], sg[i])};
            e_lr = 0;
            e_sd = 0;
            if (t[i] >= 2 * dv[i]) begin
                nb = (t[i] / (2 * dv[i]) - 1) % 32;
                e_lr = nb >= 15 && nb <= 30;
                e_sd = frame[i][31 - nb];
            end
            check($sformatf("bclk%0d", i), 32'(bclk[i]), 32'((t[i] / dv[i]) % 2));
            check($sformatf("lrclk%0d", i), 32'(lrclk[i]), 32'(e_lr));
            check($sformatf("sdata%0d", i), 32'(sdata[i]), 32'(e_sd));
            check($sformatf("strobe%0d", i), 32'(strobe[i]), 32'(e_st));
        end
    end

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++)
                if (rnd_on[i] && $urandom_range(0, 30) == 0) begin
                    lin[i] = 12'($urandom);
                    rin[i] = 12'($urandom);
                end
        end
    endtask

    task automatic wait_strobe();
        int c;
        c = 0;
        while (!strobe[0] && c < 2000) begin
            run(1);
            c++;
        end
        if (c == 2000)
            check("strobe_timeout", 32'(c), 32'(0));
    endtask

    initial begin
        rst = 1;
        enable = 0;
        lin = '{12'hFFF, 12'h801, 12'h5A5};
        rin = '{12'h000, 12'h7FF, 12'h3C3};
        rnd_on = 3'b100;
        run(3);
        rst = 0;
        enable = 1;
        run(1100);
        lin[0] = 12'h123;
        wait_strobe();
        run(5 * 16 + 4);
        lin[0] = 12'hABC;
        wait_strobe();
        run(1);
        wait_strobe();
        rnd_on = 3'b111;
        run(1500);
        wait_strobe();
        run(20 * 16 + 3);
        enable = 0;
        run(4);
        enable = 1;
        run(1200);
        run(37);
        #2 rst = 1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("arst_bclk%0d", i), 32'(bclk[i]), 32'(0));
            check($sformatf("arst_lrclk%0d", i), 32'(lrclk[i]), 32'(0));
            check($sformatf("arst_sdata%0d", i), 32'(sdata[i]), 32'(0));
            check($sformatf("arst_strobe%0d", i), 32'(strobe[i]), 32'(0));
        end
        @(negedge clk);
        run(2);
        rst = 0;
        run(1200);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
